axis_mesh_packetizer: RTL and testbench
=======================================

Name: axis_mesh_packetizer

Overview:
- Ingress packetizer directly upstream of the AXI-Stream mesh NoC ingress port (one instance per node).
- Combines a per-packet descriptor (destination, id, length, user) with a raw data-beat stream to produce a framed AXI-Stream packet.
- tid/tdest/tuser are held constant for the whole packet; tlast is generated on the final beat.
- Packets addressed to nonexistent nodes are drained and flagged, never injected.

Parameters:
- TID_WIDTH, 2, width of packet id
- TDEST_WIDTH, 4, width of destination node index
- TDATA_WIDTH, 512, data beat width
- TUSER_WIDTH, 32, sideband width
- LEN_WIDTH, 8, descriptor length field width; encodes beats-1
- NUM_NODES, 16, valid destinations are 0..NUM_NODES-1

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- desc_valid  in  1  descriptor valid
- desc_ready  out  1  descriptor accept
- desc_dest  in  TDEST_WIDTH  destination node
- desc_id  in  TID_WIDTH  packet id
- desc_len  in  LEN_WIDTH  beats minus one
- desc_user  in  TUSER_WIDTH  sideband for all beats
- s_data_tvalid  in  1  raw beat valid
- s_data_tready  out  1  raw beat accept
- s_data_tdata  in  TDATA_WIDTH  raw beat
- m_axis_tvalid  out  1  to mesh ingress
- m_axis_tready  in  1  from mesh ingress
- m_axis_tdata  out  TDATA_WIDTH  data
- m_axis_tlast  out  1  last beat of packet
- m_axis_tuser  out  TUSER_WIDTH  latched desc_user
- m_axis_tid  out  TID_WIDTH  latched desc_id
- m_axis_tdest  out  TDEST_WIDTH  latched desc_dest
- err_dest  out  1  one-cycle pulse on a dropped descriptor
- busy  out  1  state != IDLE or output buffer non-empty
- stat_pkts  out  32  packets emitted (optional feature)
- stat_beats  out  32  beats emitted (optional feature)

Behaviour:
- Reset values:
  - state=IDLE
  - m_axis_tvalid=0, m_axis_tlast=0; tdata/tuser/tid/tdest=0
  - err_dest=0, busy=0, s_data_tready=0, stats=0
  - desc_ready=1; no capture can occur while in reset.
- Handshakes: a transfer occurs when valid&&ready at a rising edge. Once m_axis_tvalid is asserted, its payload must not change until m_axis_tready.
- States:
  - IDLE: desc_ready=1, s_data_tready=0.
    - Descriptor accepted with desc_dest<NUM_NODES: latch all fields, beat_cnt=0, go to SEND.
    - Descriptor accepted with desc_dest>=NUM_NODES: latch desc_len, beat_cnt=0, assert err_dest the next cycle, go to DRAIN.
  - SEND: s_data_tready = output buffer not full.
    - Each accepted beat is written to the output buffer with the latched sideband, tlast=(beat_cnt==len), then beat_cnt+1.
    - On the last beat, desc_ready=1 in the same cycle, enabling back-to-back packets with zero bubble. If a descriptor is accepted there, take the IDLE transition targets directly; otherwise go to IDLE.
  - DRAIN: s_data_tready=1. Accept and discard len+1 beats; nothing reaches m_axis. Last-beat desc_ready behaviour is identical to SEND.
- Output buffer: 2-entry skid. An accepted raw beat appears on m_axis at the next cycle when the buffer is empty (latency 1). Full throughput is sustained under continuous m_axis_tready. s_data_tready is driven from registered occupancy only; there is no combinational path from m_axis_tready.
- beat_cnt is LEN_WIDTH bits. desc_len=0 gives a 1-beat packet with tlast on that beat. desc_len=all-ones gives 2^LEN_WIDTH beats; the counter never wraps mid-packet.
- Simultaneous buffer push and pop keeps occupancy unchanged.
- An asynchronous reset mid-packet discards buffer contents and the partial packet, and the block returns to IDLE. Upstream is responsible for re-sending.
- busy=0 only when in IDLE and the buffer is empty.

Optional Feature:
- Macro: AXIS_PACKETIZER_STATS_EN.
- Defined: stat_pkts increments on each m_axis transfer with tlast=1; stat_beats increments on each m_axis transfer. Both are 32-bit, wrap modulo 2^32, reset to 0, and do not count drained packets.
- Undefined: stat_pkts and stat_beats are tied to 0 and no counter logic is generated.

Test Plan:
- Desc dest=5, id=2, len=3, user=0xA5; 4 beats D0..D3, m_axis_tready=1 → 4 output beats, tdest=5, tid=2, tuser=0xA5 on each, tlast only on D3, first beat one cycle after D0 accepted.
- Two descriptors back-to-back (len=0, then len=1) with continuous data and ready → 3 consecutive output cycles, no bubble; tlast on beats 1 and 3.
- Desc dest=16 (NUM_NODES=16), len=2; 3 beats → err_dest pulses once, no m_axis_tvalid, next valid descriptor accepted on the 3rd drained beat.
- m_axis_tready held 0 during a 4-beat packet → exactly 2 beats accepted, s_data_tready=0, output payload stable; releasing ready delivers all 4 beats in order.
- rst_n asserted after 2 of 4 beats → all outputs at reset values immediately, busy=0; a new len=0 packet after reset emits 1 beat with tlast=1.
- With AXIS_PACKETIZER_STATS_EN defined, send 3 packets of len=1 plus 1 drained packet → stat_pkts=3, stat_beats=6.

Source files
------------

// File: rtl/axis_mesh_packetizer.sv
// Mesh ingress packetizer: frames a raw beat stream with per-packet descriptor sideband.
// Optional packet/beat statistics are enabled by defining AXIS_PACKETIZER_STATS_EN.
module axis_mesh_packetizer #(
    parameter int TID_WIDTH   = 2,
    parameter int TDEST_WIDTH = 4,
    parameter int TDATA_WIDTH = 512,
    parameter int TUSER_WIDTH = 32,
    parameter int LEN_WIDTH   = 8,
    parameter int NUM_NODES   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   desc_valid,
    output logic                   desc_ready,
    input  logic [TDEST_WIDTH-1:0] desc_dest,
    input  logic [TID_WIDTH-1:0]   desc_id,
    input  logic [LEN_WIDTH-1:0]   desc_len,
    input  logic [TUSER_WIDTH-1:0] desc_user,
    input  logic                   s_data_tvalid,
    output logic                   s_data_tready,
    input  logic [TDATA_WIDTH-1:0] s_data_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                   m_axis_tlast,
    output logic [TUSER_WIDTH-1:0] m_axis_tuser,
    output logic [TID_WIDTH-1:0]   m_axis_tid,
    output logic [TDEST_WIDTH-1:0] m_axis_tdest,
    output logic                   err_dest,
    output logic                   busy,
    output logic [31:0]            stat_pkts,
    output logic [31:0]            stat_beats,
    output logic [1:0]             dbg_state
);

    // All handshakes: a transfer happens on a rising edge where valid && ready;
    // m_axis payload is held stable from tvalid assertion until tready.

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [31:0] NUM_NODES_U = NUM_NODES;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [LEN_WIDTH-1:0]   r_len;
    logic [LEN_WIDTH-1:0]   r_beat_cnt;
    logic [TID_WIDTH-1:0]   r_id;
    logic [TDEST_WIDTH-1:0] r_dest;
    logic [TUSER_WIDTH-1:0] r_user;
    logic                   r_err_dest;

    logic [TDATA_WIDTH-1:0] r_buf_data [2];
    logic [TUSER_WIDTH-1:0] r_buf_user [2];
    logic [TID_WIDTH-1:0]   r_buf_id   [2];
    logic [TDEST_WIDTH-1:0] r_buf_dest [2];
    logic [1:0]             r_buf_last;
    logic                   r_wr_ptr;
    logic                   r_rd_ptr;
    logic [1:0]             r_count;

    logic w_dest_ok;
    logic w_sready;
    logic w_beat_fire;
    logic w_last_beat;
    logic w_desc_fire;
    logic w_push;
    logic w_pop;

    assign w_dest_ok   = {{(32-TDEST_WIDTH){1'b0}}, desc_dest} < NUM_NODES_U;
    // Raw-side ready depends only on registered state/occupancy, never on m_axis_tready.
    assign w_sready    = (r_state == ST_SEND) ? (r_count != 2'd2) : (r_state == ST_DRAIN);
    assign w_beat_fire = s_data_tvalid && w_sready;
    assign w_last_beat = w_beat_fire && (r_beat_cnt == r_len);
    assign desc_ready  = (r_state == ST_IDLE) || w_last_beat;
    assign w_desc_fire = desc_valid && desc_ready;
    assign w_push      = w_beat_fire && (r_state == ST_SEND);
    assign w_pop       = m_axis_tvalid && m_axis_tready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (desc_valid)
                    w_state_nxt = w_dest_ok ? ST_SEND : ST_DRAIN;
            end
            ST_SEND, ST_DRAIN: begin
                if (w_last_beat) begin
                    if (desc_valid)
                        w_state_nxt = w_dest_ok ? ST_SEND : ST_DRAIN;
                    else
                        w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len      <= '0;
            r_beat_cnt <= '0;
            r_id       <= '0;
            r_dest     <= '0;
            r_user     <= '0;
            r_err_dest <= 1'b0;
        end else begin
            r_err_dest <= w_desc_fire && !w_dest_ok;
            if (w_desc_fire) begin
                r_len      <= desc_len;
                r_beat_cnt <= '0;
                if (w_dest_ok) begin
                    r_id   <= desc_id;
                    r_dest <= desc_dest;
                    r_user <= desc_user;
                end
            end else if (w_beat_fire) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
        end
    end

    // Two-entry skid FIFO; head entry stays put until popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_buf_data[i] <= '0;
                r_buf_user[i] <= '0;
                r_buf_id[i]   <= '0;
                r_buf_dest[i] <= '0;
            end
            r_buf_last <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            if (w_push) begin
                r_buf_data[r_wr_ptr] <= s_data_tdata;
                r_buf_user[r_wr_ptr] <= r_user;
                r_buf_id[r_wr_ptr]   <= r_id;
                r_buf_dest[r_wr_ptr] <= r_dest;
                r_buf_last[r_wr_ptr] <= (r_beat_cnt == r_len);
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign m_axis_tvalid = (r_count != 2'd0);
    assign m_axis_tdata  = r_buf_data[r_rd_ptr];
    assign m_axis_tuser  = r_buf_user[r_rd_ptr];
    assign m_axis_tid    = r_buf_id[r_rd_ptr];
    assign m_axis_tdest  = r_buf_dest[r_rd_ptr];
    assign m_axis_tlast  = r_buf_last[r_rd_ptr];
    assign err_dest      = r_err_dest;
    assign busy          = (r_state != ST_IDLE) || (r_count != 2'd0);
    assign s_data_tready = w_sready;
    assign dbg_state     = r_state;

`ifdef AXIS_PACKETIZER_STATS_EN
    logic [31:0] r_stat_pkts;
    logic [31:0] r_stat_beats;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_pkts  <= '0;
            r_stat_beats <= '0;
        end else if (w_pop) begin
            r_stat_beats <= r_stat_beats + 32'd1;
            if (m_axis_tlast)
                r_stat_pkts <= r_stat_pkts + 32'd1;
        end
    end

    assign stat_pkts  = r_stat_pkts;
    assign stat_beats = r_stat_beats;
`else
    assign stat_pkts  = 32'd0;
    assign stat_beats = 32'd0;
`endif

endmodule

// File: tb/tb_axis_mesh_packetizer.sv
// Directed self-checking bench for axis_mesh_packetizer (dest width widened so dest=16 is expressible).
module tb_axis_mesh_packetizer;

    localparam int TID_W   = 2;
    localparam int TDEST_W = 5;
    localparam int TDATA_W = 512;
    localparam int TUSER_W = 32;
    localparam int LEN_W   = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               desc_valid;
    logic               desc_ready;
    logic [TDEST_W-1:0] desc_dest;
    logic [TID_W-1:0]   desc_id;
    logic [LEN_W-1:0]   desc_len;
    logic [TUSER_W-1:0] desc_user;
    logic               s_data_tvalid;
    logic               s_data_tready;
    logic [TDATA_W-1:0] s_data_tdata;
    logic               m_axis_tvalid;
    logic               m_axis_tready;
    logic [TDATA_W-1:0] m_axis_tdata;
    logic               m_axis_tlast;
    logic [TUSER_W-1:0] m_axis_tuser;
    logic [TID_W-1:0]   m_axis_tid;
    logic [TDEST_W-1:0] m_axis_tdest;
    logic               err_dest;
    logic               busy;
    logic [31:0]        stat_pkts;
    logic [31:0]        stat_beats;
    logic [1:0]         dbg_state;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    int          cyc_q[$];

    axis_mesh_packetizer #(
        .TID_WIDTH(TID_W), .TDEST_WIDTH(TDEST_W), .TDATA_WIDTH(TDATA_W),
        .TUSER_WIDTH(TUSER_W), .LEN_WIDTH(LEN_W), .NUM_NODES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_dest(desc_dest),
        .desc_id(desc_id), .desc_len(desc_len), .desc_user(desc_user),
        .s_data_tvalid(s_data_tvalid), .s_data_tready(s_data_tready), .s_data_tdata(s_data_tdata),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .m_axis_tid(m_axis_tid),
        .m_axis_tdest(m_axis_tdest), .err_dest(err_dest), .busy(busy),
        .stat_pkts(stat_pkts), .stat_beats(stat_beats), .dbg_state(dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // {tlast, tid, tdest, tuser[7:0], tdata[15:0]}
    function automatic logic [31:0] ent(input logic last, input logic [1:0] id,
                                        input logic [4:0] dest, input logic [7:0] user,
                                        input logic [15:0] data);
        return {last, id, dest, user, data};
    endfunction

    // output monitor: a transfer seen at negedge completes on the following posedge
    always @(negedge clk) begin
        if (rst_n && m_axis_tvalid && m_axis_tready) begin
            got_q.push_back(ent(m_axis_tlast, m_axis_tid, m_axis_tdest,
                                m_axis_tuser[7:0], m_axis_tdata[15:0]));
            cyc_q.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_desc(input logic [4:0] d, input logic [1:0] id,
                              input logic [7:0] len, input logic [31:0] user);
        logic rdy;
        int   n;
        desc_valid = 1'b1;
        desc_dest  = d;
        desc_id    = id;
        desc_len   = len;
        desc_user  = user;
        n = 0;
        do begin
            @(negedge clk);
            rdy = desc_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 50);
        chk("desc_handshake", rdy, 1);
        desc_valid = 1'b0;
    endtask

    task automatic drive_beat(input logic [15:0] v);
        logic rdy;
        int   n;
        s_data_tvalid = 1'b1;
        s_data_tdata  = TDATA_W'(v);
        n = 0;
        do begin
            @(negedge clk);
            rdy = s_data_tready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 50);
        chk("beat_handshake", rdy, 1);
        s_data_tvalid = 1'b0;
    endtask

    task automatic compare_q(input string tag);
        logic [31:0] e;
        logic [31:0] g;
        repeat (6) @(posedge clk);
        #1;
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            chk(tag, g, e);
        end
        got_q.delete();
        cyc_q.delete();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst_n = 1'b0; desc_valid = 1'b0; desc_dest = '0; desc_id = '0; desc_len = '0;
        desc_user = '0; s_data_tvalid = 1'b0; s_data_tdata = '0; m_axis_tready = 1'b1;

        // reset values
        @(negedge clk);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("rst_tdata", m_axis_tdata[63:0], 0);
        chk("rst_busy", busy, 0);
        chk("rst_desc_ready", desc_ready, 1);
        chk("rst_s_tready", s_data_tready, 0);
        chk("rst_err", err_dest, 0);
        chk("rst_stats", {stat_pkts, stat_beats}, 0);
        @(posedge clk); #1; rst_n = 1'b1;

        // basic 4-beat packet, latency 1
        drive_desc(5, 2, 3, 32'hA5);
        chk("send_state", dbg_state, 1);
        drive_beat(16'hD000);
        chk("lat_tvalid", m_axis_tvalid, 1);
        chk("lat_tdata", m_axis_tdata[15:0], 16'hD000);
        chk("lat_tdest", m_axis_tdest, 5);
        chk("lat_tid", m_axis_tid, 2);
        chk("lat_tuser", m_axis_tuser, 32'hA5);
        chk("lat_tlast", m_axis_tlast, 0);
        drive_beat(16'hD001);
        drive_beat(16'hD002);
        drive_beat(16'hD003);
        for (int i = 0; i < 4; i++) exp_q.push_back(ent(i == 3, 2, 5, 8'hA5, 16'hD000 + 16'(i)));
        compare_q("pkt4");
        chk("idle_busy", busy, 0);

        // back-to-back: len=0 then len=1, no bubble
        drive_desc(3, 1, 0, 32'h11);
        desc_valid = 1'b1; desc_dest = 7; desc_id = 3; desc_len = 1; desc_user = 32'h22;
        s_data_tvalid = 1'b1; s_data_tdata = TDATA_W'(16'hE000);
        @(negedge clk);
        chk("b2b_desc_ready", desc_ready, 1);
        chk("b2b_sready0", s_data_tready, 1);
        @(posedge clk); #1;
        desc_valid = 1'b0; s_data_tdata = TDATA_W'(16'hE001);
        @(negedge clk);
        chk("b2b_sready1", s_data_tready, 1);
        chk("b2b_desc_busy", desc_ready, 0);
        @(posedge clk); #1;
        s_data_tdata = TDATA_W'(16'hE002);
        @(negedge clk);
        chk("b2b_sready2", s_data_tready, 1);
        @(posedge clk); #1;
        s_data_tvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("b2b_gap01", cyc_q[1] - cyc_q[0], 1);
        chk("b2b_gap12", cyc_q[2] - cyc_q[1], 1);
        exp_q.push_back(ent(1, 1, 3, 8'h11, 16'hE000));
        exp_q.push_back(ent(0, 3, 7, 8'h22, 16'hE001));
        exp_q.push_back(ent(1, 3, 7, 8'h22, 16'hE002));
        compare_q("b2b");

        // maximum length: 256 beats, tlast only on the final one
        drive_desc(1, 0, 8'hFF, 32'h88);
        for (int i = 0; i < 256; i++) begin
            drive_beat(16'h1000 + 16'(i));
            exp_q.push_back(ent(i == 255, 0, 1, 8'h88, 16'h1000 + 16'(i)));
        end
        compare_q("maxlen");
        chk("maxlen_idle", busy, 0);

        // drained packet to dest 16, next descriptor on 3rd drained beat
        drive_desc(16, 1, 2, 32'h33);
        chk("drain_err_pulse", err_dest, 1);
        chk("drain_state", dbg_state, 2);
        drive_beat(16'hF000);
        chk("drain_err_once", err_dest, 0);
        s_data_tvalid = 1'b1; s_data_tdata = TDATA_W'(16'hF001);
        @(negedge clk);
        chk("drain_mid_desc_ready", desc_ready, 0);
        @(posedge clk); #1;
        s_data_tdata = TDATA_W'(16'hF002);
        desc_valid = 1'b1; desc_dest = 2; desc_id = 0; desc_len = 0; desc_user = 32'h44;
        @(negedge clk);
        chk("drain_last_desc_ready", desc_ready, 1);
        chk("drain_sready", s_data_tready, 1);
        @(posedge clk); #1;
        desc_valid = 1'b0; s_data_tvalid = 1'b0;
        chk("drain_next_state", dbg_state, 1);
        chk("drain_no_err", err_dest, 0);
        drive_beat(16'hC000);
        exp_q.push_back(ent(1, 0, 2, 8'h44, 16'hC000));
        compare_q("drain");

        // backpressure: only 2 beats buffered, payload held
        m_axis_tready = 1'b0;
        drive_desc(9, 2, 3, 32'h55);
        s_data_tvalid = 1'b1; s_data_tdata = TDATA_W'(16'hB000);
        @(posedge clk); #1;
        s_data_tdata = TDATA_W'(16'hB001);
        @(posedge clk); #1;
        s_data_tdata = TDATA_W'(16'hB002);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_sready", s_data_tready, 0);
            chk("bp_tvalid", m_axis_tvalid, 1);
            chk("bp_tdata", m_axis_tdata[15:0], 16'hB000);
            chk("bp_tlast", m_axis_tlast, 0);
        end
        @(posedge clk); #1;
        m_axis_tready = 1'b1;
        drive_beat(16'hB002);
        drive_beat(16'hB003);
        for (int i = 0; i < 4; i++) exp_q.push_back(ent(i == 3, 2, 9, 8'h55, 16'hB000 + 16'(i)));
        compare_q("bp");

        // asynchronous reset mid-packet
        m_axis_tready = 1'b0;
        drive_desc(4, 1, 3, 32'h66);
        drive_beat(16'hA000);
        drive_beat(16'hA001);
        rst_n = 1'b0;
        #1;
        chk("arst_tvalid", m_axis_tvalid, 0);
        chk("arst_tlast", m_axis_tlast, 0);
        chk("arst_tdata", m_axis_tdata[63:0], 0);
        chk("arst_side", {m_axis_tuser, 2'(m_axis_tid), 5'(m_axis_tdest)}, 0);
        chk("arst_busy", busy, 0);
        chk("arst_desc_ready", desc_ready, 1);
        chk("arst_sready", s_data_tready, 0);
        chk("arst_state", dbg_state, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; m_axis_tready = 1'b1;
        drive_desc(6, 3, 0, 32'h77);
        drive_beat(16'h5000);
        exp_q.push_back(ent(1, 3, 6, 8'h77, 16'h5000));
        compare_q("arst");

        // statistics: 3 emitted len=1 packets plus 1 drained
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("stat_reset", {stat_pkts, stat_beats}, 0);
        for (int p = 0; p < 3; p++) begin
            drive_desc(5'(10 + p), 2'(p), 1, 32'h90 + 32'(p));
            drive_beat(16'h7000 + 16'(2 * p));
            drive_beat(16'h7001 + 16'(2 * p));
            exp_q.push_back(ent(0, 2'(p), 5'(10 + p), 8'h90 + 8'(p), 16'h7000 + 16'(2 * p)));
            exp_q.push_back(ent(1, 2'(p), 5'(10 + p), 8'h90 + 8'(p), 16'h7001 + 16'(2 * p)));
        end
        drive_desc(20, 0, 1, 32'h99);
        drive_beat(16'h7F00);
        drive_beat(16'h7F01);
        compare_q("stats_data");
`ifdef AXIS_PACKETIZER_STATS_EN
        chk("stat_pkts", stat_pkts, 3);
        chk("stat_beats", stat_beats, 6);
`else
        chk("stat_pkts_off", stat_pkts, 0);
        chk("stat_beats_off", stat_beats, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
